// File: rtl/bcd_adder_4digit_pkg.sv
// Shared constants and types for the packed-BCD adder.
// Digit-level helpers live here so the top and the per-digit adder agree on widths.
package bcd_adder_4digit_pkg;

  localparam int unsigned BCD_DIGIT_W   = 4;
  localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;
  localparam logic [4:0]  BCD_CORR      = 5'd6;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  function automatic logic digit_is_bad(input bcd_digit_t d);
    return d > BCD_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/bcd_adder_4digit_digit_adder.sv
// Single-digit combinational BCD adder with +6 correction and non-BCD operand flag.
module bcd_digit_adder
  import bcd_adder_4digit_pkg::*;
(
  input  bcd_digit_t a_d,
  input  bcd_digit_t b_d,
  input  logic       ci,
  output bcd_digit_t s_d,
  output logic       co,
  output logic       bad
);

  logic [4:0] raw;

  always_comb begin
    raw = {1'b0, a_d} + {1'b0, b_d} + {4'b0000, ci};
    s_d = raw[3:0];
    co  = 1'b0;
    // A 4-bit add of the correction wraps exactly like (raw + 6)[3:0].
    if (raw > {1'b0, BCD_MAX_DIGIT}) begin
      s_d = raw[3:0] + BCD_CORR[3:0];
      co  = 1'b1;
    end
    bad = digit_is_bad(a_d) || digit_is_bad(b_d);
  end

endmodule

// File: rtl/bcd_adder_4digit.sv
// Registered packed-BCD adder: ripple chain of digit adders, result captured on in_valid.
module bcd_adder_4digit
  import bcd_adder_4digit_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [BCD_DIGIT_W*NUM_DIGITS-1:0] a,
  input  logic [BCD_DIGIT_W*NUM_DIGITS-1:0] b,
  input  logic                          cin,
  output logic [BCD_DIGIT_W*NUM_DIGITS-1:0] sum,
  output logic                          cout,
  output logic                          out_valid,
  output logic                          digit_err
);

  localparam int unsigned W = BCD_DIGIT_W * NUM_DIGITS;

  logic [NUM_DIGITS:0]   carry;
  logic [W-1:0]          sum_comb;
  logic [NUM_DIGITS-1:0] bad_digit;

  assign carry[0] = cin;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit_adder u_digit (
      .a_d (a[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
      .b_d (b[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
      .ci  (carry[i]),
      .s_d (sum_comb[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
      .co  (carry[i+1]),
      .bad (bad_digit[i])
    );
  end

  logic [W-1:0] sum_d, sum_q;
  logic         cout_d, cout_q;
  logic         err_d, err_q;
  logic         valid_d, valid_q;

  always_comb begin
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;
    valid_d = in_valid;
    if (in_valid) begin
      sum_d  = sum_comb;
      cout_d = carry[NUM_DIGITS];
      err_d  = |bad_digit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign digit_err = err_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_bcd_adder_4digit.sv
// Directed and random checks of the registered 4-digit BCD adder against integer arithmetic.
module tb_bcd_adder_4digit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic [15:0] sum;
  logic        cout;
  logic        out_valid;
  logic        digit_err;

  int n_checks;
  int n_fail;

  bcd_adder_4digit #(
    .NUM_DIGITS (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid),
    .digit_err (digit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one valid vector before a rising edge, sample 1 time unit after it.
  task automatic apply(input logic [15:0] av, input logic [15:0] bv, input logic c);
    @(negedge clk);
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    cin      = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag, input int unsigned es, input int unsigned ec,
                              input int unsigned ee);
    check_eq({tag, ".sum"}, 32'(sum), es);
    check_eq({tag, ".cout"}, 32'(cout), ec);
    check_eq({tag, ".err"}, 32'(digit_err), ee);
    check_eq({tag, ".valid"}, 32'(out_valid), 1);
  endtask

  function automatic int unsigned int_to_bcd(input int unsigned v);
    int unsigned r = 0;
    for (int i = 0; i < 4; i++) begin
      r = r | ((v % 10) << (4 * i));
      v = v / 10;
    end
    return r;
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("reset.sum", 32'(sum), 0);
    check_eq("reset.cout", 32'(cout), 0);
    check_eq("reset.valid", 32'(out_valid), 0);
    check_eq("reset.err", 32'(digit_err), 0);
    @(negedge clk);
    rst = 1'b0;

    apply(16'h1234, 16'h4321, 1'b0);
    check_result("basic", 32'h5555, 0, 0);
    apply(16'h0599, 16'h0001, 1'b0);
    check_result("ripple", 32'h0600, 0, 0);
    apply(16'h9999, 16'h0000, 1'b1);
    check_result("wrap", 32'h0000, 1, 0);
    apply(16'h9999, 16'h9999, 1'b1);
    check_result("max", 32'h9999, 1, 0);
    apply(16'h000F, 16'h0001, 1'b0);
    check_result("nonbcd", 32'h0016, 0, 1);
    apply(16'h0050, 16'h0A00, 1'b0);
    check_result("nonbcd_b", 32'h1050, 0, 1);

    // Idle cycle: registered result holds, out_valid drops.
    @(negedge clk);
    in_valid = 1'b0;
    a        = 16'h1111;
    b        = 16'h1111;
    @(posedge clk);
    #1;
    check_eq("idle.sum", 32'(sum), 32'h1050);
    check_eq("idle.err", 32'(digit_err), 1);
    check_eq("idle.valid", 32'(out_valid), 0);

    // Asynchronous reset mid-cycle with a capture pending.
    apply(16'h4444, 16'h4444, 1'b0);
    check_result("pre_rst", 32'h8888, 0, 0);
    @(negedge clk);
    a        = 16'h2222;
    b        = 16'h3333;
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_async.sum", 32'(sum), 0);
    check_eq("rst_async.valid", 32'(out_valid), 0);
    @(posedge clk);
    #1;
    check_eq("rst_held.sum", 32'(sum), 0);
    check_eq("rst_held.cout", 32'(cout), 0);
    check_eq("rst_held.valid", 32'(out_valid), 0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("post_rst.sum", 32'(sum), 0);
    check_eq("post_rst.valid", 32'(out_valid), 0);
    apply(16'h0123, 16'h0877, 1'b1);
    check_result("post_rst_first", 32'h1001, 0, 0);

    // Back-to-back random valid BCD operands against integer arithmetic.
    for (int n = 0; n < 1000; n++) begin
      int unsigned ad = 0;
      int unsigned bd = 0;
      logic [15:0] ab = '0;
      logic [15:0] bb = '0;
      logic        c;
      int unsigned tot;
      for (int k = 0; k < 4; k++) begin
        int unsigned da = $urandom_range(0, 9);
        int unsigned db = $urandom_range(0, 9);
        ab[4*k +: 4] = 4'(da);
        bb[4*k +: 4] = 4'(db);
      end
      ad  = (ab[15:12] * 1000) + (ab[11:8] * 100) + (ab[7:4] * 10) + ab[3:0];
      bd  = (bb[15:12] * 1000) + (bb[11:8] * 100) + (bb[7:4] * 10) + bb[3:0];
      c   = 1'($urandom_range(0, 1));
      tot = ad + bd + 32'(c);
      apply(ab, bb, c);
      check_result("rand", int_to_bcd(tot % 10000), (tot >= 10000) ? 1 : 0, 0);
    end

    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("final.valid", 32'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_adder_4digit.md
Name: bcd_adder_4digit

Overview:
Registered 4-digit packed-BCD adder: sum = a + b + cin in decimal, with a decimal carry out. Built from a ripple chain of single-digit BCD adders with +6 correction; the result is captured in output registers one cycle after a valid input. Used wherever decimal counters and accumulators need a pipelined decimal add; it also flags non-BCD operand digits.

Parameters:
NUM_DIGITS, 4, number of BCD digits; operand/sum width = 4*NUM_DIGITS (16 at default).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  a/b/cin valid this cycle; result captured
a  input  4*NUM_DIGITS  packed BCD operand, digit 0 = bits [3:0]
b  input  4*NUM_DIGITS  packed BCD operand
cin  input  1  decimal carry into digit 0
sum  output  4*NUM_DIGITS  registered packed BCD result
cout  output  1  registered decimal carry out of the top digit
out_valid  output  1  sum/cout/digit_err updated this cycle
digit_err  output  1  registered; 1 if any a or b nibble captured was > 9

Behaviour:
- One clock (clk); rst is asynchronous and active-high.
- Reset: sum=0, cout=0, out_valid=0, digit_err=0 immediately on rst assertion, held while rst=1.
- Per digit i, combinational: s = a_i + b_i + c_i as a 5-bit value (0..31); c_0 = cin.
- If s > 9: digit_i = (s + 6)[3:0], c_{i+1} = 1; else digit_i = s[3:0], c_{i+1} = 0.
- cout = c_NUM_DIGITS. Ripple carry across digits; no carry lookahead required.
- Non-BCD nibbles (10..15) are not rejected: the same rule is applied (deterministic output) and digit_err is set for that result.
- Latency 1 cycle: on a rising clk with in_valid=1, register sum, cout, digit_err; out_valid=1 in the following cycle.
- in_valid=0: sum/cout/digit_err hold their previous values; out_valid=0 next cycle.
- Back-to-back in_valid: one result per cycle, no stall, no backpressure.
- Reset mid-operation: any pending capture is discarded; after rst deasserts, the first result appears one cycle after the next in_valid.
- Maximum valid result: 9999+9999+1 = 19999 -> sum=0x9999, cout=1.

Decomposition:
- Shared package: BCD_DIGIT_W=4, BCD_MAX_DIGIT=4'd9, BCD_CORR=5'd6, and a bcd_digit_t 4-bit typedef.
- Sub-module bcd_digit_adder: inputs (a_d, b_d, ci); outputs (s_d, co, bad), purely combinational. Instantiate NUM_DIGITS times in a generate loop inside the registered top.

Test Plan:
- a=0x1234, b=0x4321, cin=0, in_valid=1 -> next cycle sum=0x5555, cout=0, digit_err=0, out_valid=1.
- a=0x0599, b=0x0001, cin=0 -> sum=0x0600, cout=0 (ripple through two digits).
- a=0x9999, b=0x0000, cin=1 -> sum=0x0000, cout=1; a=0x9999, b=0x9999, cin=1 -> sum=0x9999, cout=1.
- a=0x000F, b=0x0001, cin=0 -> sum=0x0016, cout=0, digit_err=1.
- Assert rst asynchronously mid-cycle while in_valid=1 -> sum=0, cout=0, out_valid=0 immediately and in the following cycle; in_valid=0 afterwards -> outputs hold, out_valid=0.
- Random sweep: 1000 random valid BCD operands and cin, back-to-back -> each result equals the decimal reference (a_dec + b_dec + cin) exactly one cycle later; digit_err=0 throughout.
